// File: rtl/power_frame_arbiter_pkg.sv
// power_frame_arbiter_pkg: shared constants and FSM state encoding for the frame arbiter
package power_frame_arbiter_pkg;
  localparam int DEF_CHANNELS    = 8;
  localparam int DEF_ID_WIDTH    = 3;
  localparam int DEF_INDEX_WIDTH = 10;
  localparam int DEF_MAX_BEATS   = 4096;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/power_frame_arbiter_rr_pick.sv
// rr_pick: combinational round-robin first-one finder starting at i_ptr with wrap
//   i_req   : request vector
//   i_ptr   : highest-priority channel
//   o_grant : one-hot winner (zero when no request)
//   o_idx   : encoded winner
//   o_any   : at least one request present
module rr_pick #(
  parameter int CHANNELS = 8,
  parameter int ID_WIDTH = 3
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic [CHANNELS-1:0] o_grant,
  output logic [ID_WIDTH-1:0] o_idx,
  output logic                o_any
);
  // Scan from the farthest offset down so the nearest request at/after i_ptr is written last and wins.
  always_comb begin
    int j;
    j = 0;
    o_grant = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      j = int'(i_ptr) + i;
      j = (j >= CHANNELS) ? j - CHANNELS : j;
      if (i_req[j]) begin
        o_grant = '0;
        o_grant[j] = 1'b1;
        o_idx = ID_WIDTH'(j);
        o_any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/power_frame_arbiter.sv
// power_frame_arbiter: frame-granular round-robin mux of CHANNELS AXIS streams onto one tagged AXIS master
//   clk, rst                       : clock, async active-high reset
//   select_average                 : mode request, latched into avg_sel at each grant
//   s_tdata/s_xk/s_tvalid/s_tlast  : per-channel slave streams; s_tready per channel
//   m_tdata/m_xk/m_tid/m_tvalid/m_tlast/m_tready : registered master stream
//   avg_sel                        : mode of the current frame
//   overrun                        : one-cycle pulse when a frame is cut at MAX_BEATS
//   grant_onehot                   : current grant, zero in IDLE
module power_frame_arbiter
  import power_frame_arbiter_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int ID_WIDTH    = DEF_ID_WIDTH,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int MAX_BEATS   = DEF_MAX_BEATS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            select_average,
  input  logic [CHANNELS*32-1:0]          s_tdata,
  input  logic [CHANNELS*INDEX_WIDTH-1:0] s_xk,
  input  logic [CHANNELS-1:0]             s_tvalid,
  input  logic [CHANNELS-1:0]             s_tlast,
  output logic [CHANNELS-1:0]             s_tready,
  output logic [31:0]                     m_tdata,
  output logic [INDEX_WIDTH-1:0]          m_xk,
  output logic [ID_WIDTH-1:0]             m_tid,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  input  logic                            m_tready,
  output logic                            avg_sel,
  output logic                            overrun,
  output logic [CHANNELS-1:0]             grant_onehot
);
  localparam int CW = $clog2(MAX_BEATS) + 1;
  state_t r_state, w_next;
  logic [ID_WIDTH-1:0] r_ptr, r_gid, w_pick_idx;
  logic [CHANNELS-1:0] w_pick;
  logic [CW-1:0] r_cnt;
  logic w_any, w_room, w_acc, w_last, w_limit, w_done, w_xfer_acc;

  rr_pick #(.CHANNELS(CHANNELS), .ID_WIDTH(ID_WIDTH)) u_pick (
    .i_req(s_tvalid), .i_ptr(r_ptr), .o_grant(w_pick), .o_idx(w_pick_idx), .o_any(w_any)
  );

  assign w_room     = ~m_tvalid | m_tready;
  assign w_acc      = ((r_state == XFER && w_room) || r_state == DRAIN) && s_tvalid[r_gid];
  assign w_xfer_acc = r_state == XFER && w_acc;
  assign w_last     = s_tlast[r_gid];
  assign w_limit    = r_cnt == CW'(MAX_BEATS - 1);
  assign w_done     = r_state != IDLE && w_next == IDLE;
  // grant_onehot is zero outside XFER/DRAIN, so no state term is needed for IDLE.
  assign s_tready   = grant_onehot & {CHANNELS{r_state == DRAIN || w_room}};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_any ? XFER : IDLE;
      XFER:    w_next = !w_acc ? XFER : w_last ? IDLE : w_limit ? DRAIN : XFER;
      DRAIN:   w_next = (w_acc && w_last) ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
      r_gid <= '0;
      r_cnt <= '0;
      grant_onehot <= '0;
      avg_sel <= 1'b0;
      overrun <= 1'b0;
      m_tdata <= '0;
      m_xk <= '0;
      m_tid <= '0;
      m_tvalid <= 1'b0;
      m_tlast <= 1'b0;
    end else begin
      overrun <= w_xfer_acc && !w_last && w_limit;
      if (r_state == IDLE && w_any) begin
        grant_onehot <= w_pick;
        r_gid <= w_pick_idx;
        avg_sel <= select_average;
      end
      if (w_done) begin
        grant_onehot <= '0;
        r_ptr <= (r_gid == ID_WIDTH'(CHANNELS - 1)) ? '0 : r_gid + 1'b1;
      end
      if (w_xfer_acc) r_cnt <= (w_last || w_limit) ? '0 : r_cnt + 1'b1;
      // Truncated frames still get a terminating tlast on the last forwarded beat.
      if (w_xfer_acc) begin
        m_tdata <= s_tdata[r_gid*32 +: 32];
        m_xk <= s_xk[r_gid*INDEX_WIDTH +: INDEX_WIDTH];
        m_tid <= r_gid;
        m_tlast <= w_last | w_limit;
        m_tvalid <= 1'b1;
      end else if (m_tready) m_tvalid <= 1'b0;
    end
  end
endmodule
